bram_arbiter: RTL and testbench

- Shares one single-port, byte-write block RAM (1-cycle synchronous read) between two requesters.
- m0 is the CPU AHB-to-RAM bridge and has priority. m1 is the boot loader / DMA port.
- The block owns grant selection, starvation protection and read-data return tagging.
- It sits between both masters and the RAM instance in the SoC memory subsystem.

---
 rtl/bram_arb_pkg.sv | 8 +
 rtl/bram_arb_starve_ctr.sv | 27 ++
 rtl/bram_arbiter.sv | 82 ++++++++
 tb/tb_bram_arbiter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/bram_arb_pkg.sv
// Shared constants for the two-master block-RAM arbiter.
// Master tags, the read-enable encoding and the starvation counter width.
package bram_arb_pkg;
    localparam logic       MASTER_M0 = 1'b0;
    localparam logic       MASTER_M1 = 1'b1;
    localparam logic [3:0] WE_READ   = 4'b0000;
    localparam int         CNT_W     = 4;
endpackage

// File: rtl/bram_arb_starve_ctr.sv
// Saturating count of consecutive cycles m1 has been denied while requesting.
// limit_hit is registered state only, so it can feed the combinational grant without a loop.
module bram_arb_starve_ctr
    import bram_arb_pkg::*;
#(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic limit_hit
);
    localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != LIM)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign limit_hit = (cnt == LIM);
endmodule

// File: rtl/bram_arbiter.sv
// Shares one single-port byte-write BRAM between m0 (priority) and m1 (starvation-protected).
// Grant is combinational; read data returns one cycle after issue, tagged to the issuing master.
module bram_arbiter
    import bram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 14,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic [3:0]            m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [31:0]           m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    input  logic                  m1_req,
    input  logic [3:0]            m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [31:0]           m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [31:0]           rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_din,
    output logic [3:0]            ram_we,
    input  logic [31:0]           ram_dout
);
    logic limit_hit;
    logic rd_vld_q;
    logic rd_owner_q;
    logic issue_read;

    // m1 only beats m0 once it has been denied STARVE_LIMIT cycles in a row.
    always_comb begin
        m0_gnt   = 1'b0;
        m1_gnt   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        ram_we   = WE_READ;
        if (!rst) begin
            if (m1_req && (!m0_req || limit_hit)) begin
                m1_gnt   = 1'b1;
                ram_addr = m1_addr;
                ram_din  = m1_wdata;
                ram_we   = m1_we;
            end else if (m0_req) begin
                m0_gnt   = 1'b1;
                ram_addr = m0_addr;
                ram_din  = m0_wdata;
                ram_we   = m0_we;
            end
        end
    end

    bram_arb_starve_ctr #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .inc      (m1_req && m0_gnt),
        .clr      (m1_gnt || !m1_req),
        .limit_hit(limit_hit)
    );

    assign issue_read = (m0_gnt || m1_gnt) && (ram_we == WE_READ);

    // Owner tag travels with each read so alternating masters get their own data.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_q   <= 1'b0;
            rd_owner_q <= MASTER_M0;
        end else begin
            rd_vld_q   <= issue_read;
            rd_owner_q <= m1_gnt ? MASTER_M1 : MASTER_M0;
        end
    end

    assign m0_rvalid = rd_vld_q && (rd_owner_q == MASTER_M0);
    assign m1_rvalid = rd_vld_q && (rd_owner_q == MASTER_M1);
    assign rdata     = ram_dout;
endmodule

// File: tb/tb_bram_arbiter.sv
// Bench for bram_arbiter: behavioural byte-write BRAM, per-cycle vector table,
// hand sequences for starvation and reset, and a scoreboard for read returns.
module tb_bram_arbiter;
    localparam int AW    = 14;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m1_req;
    logic [3:0]    m0_we, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [31:0]   m0_wdata, m1_wdata;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0]   rdata, ram_din, ram_dout;
    logic [AW-1:0] ram_addr;
    logic [3:0]    ram_we;

    bram_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .rdata(rdata), .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
        .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: lanes written this cycle keep their previous douta value.
    logic [31:0] ram_mem [0:(1<<AW)-1];
    initial begin
        for (int i = 0; i < (1 << AW); i++) ram_mem[i] = '0;
        ram_dout = '0;
    end
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (ram_we[b]) ram_mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
            else           ram_dout[8*b +: 8]          <= ram_mem[ram_addr][8*b +: 8];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic          r0; logic [3:0] w0; logic [AW-1:0] a0; logic [31:0] d0;
        logic          r1; logic [3:0] w1; logic [AW-1:0] a1; logic [31:0] d1;
        logic          e0; logic       e1;
    } vec_t;

    typedef struct { int due; logic owner; logic [31:0] data; } rd_exp_t;

    rd_exp_t     sb[$];
    logic [31:0] exp_mem [int];
    int          n_pass  = 0;
    int          n_total = 0;
    bit          mon_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, req);
    endtask

    function automatic logic [31:0] mem_rd(input logic [AW-1:0] a);
        return exp_mem.exists(int'(a)) ? exp_mem[int'(a)] : 32'h0;
    endfunction

    task automatic mem_wr(input logic [AW-1:0] a, input logic [3:0] we, input logic [31:0] d);
        logic [31:0] w;
        w = mem_rd(a);
        for (int b = 0; b < 4; b++) if (we[b]) w[8*b +: 8] = d[8*b +: 8];
        exp_mem[int'(a)] = w;
    endtask

    // One cycle: drive after the edge, check the issue on the falling edge, record expectations.
    task automatic step(input vec_t v, input logic r);
        logic [AW-1:0] ea;
        logic [31:0]   ed;
        logic [3:0]    ew;
        @(posedge clk);
        #1;
        rst = r;
        m0_req = v.r0; m0_we = v.w0; m0_addr = v.a0; m0_wdata = v.d0;
        m1_req = v.r1; m1_we = v.w1; m1_addr = v.a1; m1_wdata = v.d1;
        @(negedge clk);
        ea = '0; ed = '0; ew = 4'b0000;
        if (!r && v.e0) begin ea = v.a0; ed = v.d0; ew = v.w0; end
        if (!r && v.e1) begin ea = v.a1; ed = v.d1; ew = v.w1; end
        chk("m0_gnt", 32'(m0_gnt), 32'(v.e0 && !r));
        chk("m1_gnt", 32'(m1_gnt), 32'(v.e1 && !r));
        chk("ram_we", 32'(ram_we), 32'(ew));
        chk("ram_addr", 32'(ram_addr), 32'(ea));
        chk("ram_din", ram_din, ed);
        if (!r && (v.e0 || v.e1)) begin
            if (ew == 4'b0000) sb.push_back('{cyc + 1, v.e1, mem_rd(ea)});
            else               mem_wr(ea, ew, ed);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                rd_exp_t e;
                e = sb.pop_front();
                chk("m0_rvalid", 32'(m0_rvalid), 32'(e.owner == 1'b0));
                chk("m1_rvalid", 32'(m1_rvalid), 32'(e.owner == 1'b1));
                chk("rdata", rdata, e.data);
            end else begin
                chk("no_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'(0));
            end
        end
    end

    vec_t tbl [13];
    vec_t both_rd, idle;

    initial begin
        rst = 1'b1;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;

        idle    = '{0, 4'h0, 14'h0,   32'h0, 0, 4'h0, 14'h0,   32'h0, 0, 0};
        both_rd = '{1, 4'h0, 14'h010, 32'h0, 1, 4'h0, 14'h020, 32'h0, 1, 0};

        tbl[0]  = '{1, 4'hF, 14'h010, 32'hDEADBEEF, 0, 4'h0, 14'h000, 32'h0,        1, 0};
        tbl[1]  = '{1, 4'h0, 14'h010, 32'h0,        0, 4'h0, 14'h000, 32'h0,        1, 0};
        tbl[2]  = '{0, 4'h0, 14'h000, 32'h0,        1, 4'hF, 14'h020, 32'h11223344, 0, 1};
        tbl[3]  = '{0, 4'h0, 14'h000, 32'h0,        1, 4'h1, 14'h020, 32'h000000AA, 0, 1};
        tbl[4]  = '{0, 4'h0, 14'h000, 32'h0,        1, 4'h0, 14'h020, 32'h0,        0, 1};
        tbl[5]  = '{1, 4'hF, 14'h001, 32'hA0A00001, 0, 4'h0, 14'h000, 32'h0,        1, 0};
        tbl[6]  = '{0, 4'h0, 14'h000, 32'h0,        1, 4'hF, 14'h002, 32'hB0B00002, 0, 1};
        tbl[7]  = '{1, 4'hC, 14'h003, 32'hC0C00003, 0, 4'h0, 14'h000, 32'h0,        1, 0};
        tbl[8]  = '{1, 4'h0, 14'h001, 32'h0,        0, 4'h0, 14'h000, 32'h0,        1, 0};
        tbl[9]  = '{0, 4'h0, 14'h000, 32'h0,        1, 4'h0, 14'h002, 32'h0,        0, 1};
        tbl[10] = '{1, 4'h0, 14'h003, 32'h0,        0, 4'h0, 14'h000, 32'h0,        1, 0};
        tbl[11] = '{1, 4'h0, 14'h010, 32'h0,        1, 4'h3, 14'h020, 32'h0000FFFF, 1, 0};
        tbl[12] = idle;

        // Reset with both masters requesting: nothing may reach the RAM.
        step(both_rd, 1'b1);
        step(both_rd, 1'b1);
        mon_en = 1'b1;

        for (int i = 0; i < 13; i++) step(tbl[i], 1'b0);

        // Both held high: m1 forced through every fifth cycle.
        for (int i = 0; i < 13; i++) begin
            vec_t v;
            v = both_rd;
            v.e0 = (i % 5) != 4;
            v.e1 = (i % 5) == 4;
            step(v, 1'b0);
        end

        // Reset with a pending m0 read and a partly-filled counter.
        step(both_rd, 1'b1);
        for (int i = 0; i < 5; i++) begin
            vec_t v;
            v = both_rd;
            v.e0 = (i != 4);
            v.e1 = (i == 4);
            step(v, 1'b0);
        end

        for (int i = 0; i < 10; i++) step(idle, 1'b0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
